// File: rtl/dst_sel_pkg.sv
// Shared types for the destination-select pipe.
// Entry layout and well-known register indices.
package dst_sel_pkg;

   localparam int DST_W = 5;

   localparam logic [DST_W-1:0] REG_ZERO = '0;
   localparam logic [DST_W-1:0] LINK_REG = DST_W'(31);

   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [DST_W-1:0] dst;
   } dst_entry_t;

endpackage

// File: rtl/dst_sel_pipe_match.sv
// Youngest-stage match of one query index against in-flight writers.
// Instantiated once per decode source operand.
module dst_match
   import dst_sel_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int STG_W = 2,
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] q,
   input  dst_entry_t       ent [DEPTH],
   input  logic [DEPTH-1:0] elig,
   output logic             hit,
   output logic [STG_W-1:0] stg
);

   // Walk oldest to youngest so the youngest match is the last write.
   always_comb begin
      hit = 1'b0;
      stg = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i] && ent[i].valid && ent[i].wr &&
             (DST_W'(q) != REG_ZERO) &&
             (ent[i].dst == DST_W'(q))) begin
            hit = 1'b1;
            stg = STG_W'(i);
         end
      end
   end

endmodule

// File: rtl/dst_sel_pipe.sv
// Destination select + delay line to write-back with RAW hazard detect.
// Define DST_SEL_PIPE_WB_BYPASS_EN to drop the write-back stage from compares.
module dst_sel_pipe
   import dst_sel_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 3,
   parameter int SEL_W   = 2,
   parameter int DEPTH   = 3,
   parameter int STG_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     reg_write,
   input  logic [NUM_SRC*REG_W-1:0] src_idx,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [REG_W-1:0]         rs_q,
   input  logic [REG_W-1:0]         rt_q,
   output logic                     hazard_rs,
   output logic                     hazard_rt,
   output logic [STG_W-1:0]         rs_stage,
   output logic [STG_W-1:0]         rt_stage,
   output logic                     wb_we,
   output logic [REG_W-1:0]         wb_dst
);

   logic [REG_W-1:0] dst;
   logic             wr;
   dst_entry_t       cap;
   dst_entry_t       stg_q [DEPTH];
   logic [DEPTH-1:0] elig;

   // Out-of-range selects fall through to register zero.
   always_comb begin
      dst = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            dst = src_idx[k*REG_W +: REG_W];
         end
      end
   end

   always_comb begin
      wr        = in_valid & reg_write & (DST_W'(dst) != REG_ZERO);
      cap       = '0;
      cap.valid = in_valid;
      cap.wr    = wr;
      cap.dst   = DST_W'(dst);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg_q[i] <= '0;
         end
      end else begin
         if (flush) begin
            stg_q[0] <= '0;
         end else if (!stall) begin
            stg_q[0] <= cap;
         end
         if (!stall) begin
            for (int i = 1; i < DEPTH; i++) begin
               stg_q[i] <= stg_q[i-1];
            end
         end
      end
   end

   // Gating with stall keeps a held last-stage entry to a single write.
   always_comb begin
      wb_we  = stg_q[DEPTH-1].valid & stg_q[DEPTH-1].wr & ~stall;
      wb_dst = REG_W'(stg_q[DEPTH-1].dst);
   end

   always_comb begin
      elig = '1;
`ifdef DST_SEL_PIPE_WB_BYPASS_EN
      elig[DEPTH-1] = 1'b0;
`else
      elig[DEPTH-1] = 1'b1;
`endif
   end

   dst_match #(
      .DEPTH (DEPTH),
      .STG_W (STG_W),
      .REG_W (REG_W)
   ) u_match_rs (
      .q    (rs_q),
      .ent  (stg_q),
      .elig (elig),
      .hit  (hazard_rs),
      .stg  (rs_stage)
   );

   dst_match #(
      .DEPTH (DEPTH),
      .STG_W (STG_W),
      .REG_W (REG_W)
   ) u_match_rt (
      .q    (rt_q),
      .ent  (stg_q),
      .elig (elig),
      .hit  (hazard_rt),
      .stg  (rt_stage)
   );

endmodule
